// File: rtl/dram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dram_arb_pkg
// Purpose  : Shared types and constants for the DRAM read-address arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dram_arb_pkg;

  localparam int DEF_ADDR_W     = 24;
  localparam int DEF_PERIOD_W   = 14;
  localparam int DEFAULT_PERIOD = 2272;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SWEEP    = 2'd1,
    THROTTLE = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [1:0]              pad;
    logic [DEF_PERIOD_W-1:0] period;
    logic [DEF_ADDR_W-1:0]   addr;
  } fifo_word_t;

  localparam int DATA_W = $bits(fifo_word_t);

  // Saturating increment used by the optional statistics counters
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && !(&v)) ? v + 32'd1 : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_select.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_select
// Purpose  : Finds the lowest valid index at or above a base pointer and
//            reports whether nothing valid lies above that choice.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_select #(
  parameter int N     = 8,
  parameter int PTR_W = 3
) (
  input  logic [N-1:0]     valid,
  input  logic [PTR_W-1:0] base,
  output logic [PTR_W-1:0] sel,
  output logic             found,
  output logic             last
);

  // Lowest qualifying index wins; last looks at everything above the winner
  always_comb begin
    sel   = '0;
    found = 1'b0;
    last  = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (valid[i] && (i >= int'(base))) begin
        sel   = PTR_W'(i);
        found = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (valid[j] && (j > int'(sel))) last = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dram_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dram_read_arbiter
// Purpose  : Handshake-driven sweep scheduler feeding DRAM read addresses from
//            the instrument voices into the CDC read-address FIFO.
//            Optional statistics counters: define DRAM_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dram_read_arbiter
  import dram_arb_pkg::*;
#(
  parameter int INSTRUMENT_COUNT = 8,
  parameter int ADDR_W           = DEF_ADDR_W,
  parameter int PERIOD_W         = DEF_PERIOD_W
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [INSTRUMENT_COUNT-1:0][ADDR_W-1:0] req_addr,
  input  logic [INSTRUMENT_COUNT-1:0]             req_valid,
  output logic [INSTRUMENT_COUNT-1:0]             req_ready,
  input  logic [PERIOD_W-1:0]                     sample_period,
  output logic                                    m_axis_tvalid,
  input  logic                                    m_axis_tready,
  output logic [DATA_W-1:0]                       m_axis_tdata,
  output logic                                    m_axis_tlast,
  input  logic                                    fifo_prog_full,
`ifdef DRAM_ARB_STATS_EN
  output logic [31:0]                             stat_grants,
  output logic [31:0]                             stat_throttle_cycles,
`endif
  output logic                                    sweep_active
);

  localparam int PTR_W = (INSTRUMENT_COUNT > 1) ? $clog2(INSTRUMENT_COUNT) : 1;

  arb_state_t          state_q, state_d, ret_q, ret_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d, sel;
  logic [PERIOD_W-1:0] period_hold_q, period_hold_d, period_src;
  logic                tvalid_q, tvalid_d, tlast_q, tlast_d;
  fifo_word_t          tdata_q, tdata_d;
  logic                found, last, slot_free, can_grant, grant;

  rr_priority_select #(
    .N     (INSTRUMENT_COUNT),
    .PTR_W (PTR_W)
  ) u_sel (
    .valid (req_valid),
    .base  (ptr_q),
    .sel   (sel),
    .found (found),
    .last  (last)
  );

  assign slot_free = !tvalid_q || m_axis_tready;
  assign can_grant = slot_free && !fifo_prog_full;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ret_q   <= IDLE;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  // Next-state: throttle remembers where to resume, a grant ends the sweep on last
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    unique case (state_q)
      IDLE, SWEEP: begin
        if (!found) begin
          state_d = IDLE;
        end else if (fifo_prog_full) begin
          state_d = THROTTLE;
          ret_d   = state_q;
        end else if (grant) begin
          state_d = last ? IDLE : SWEEP;
        end
      end
      THROTTLE: if (!fifo_prog_full) state_d = ret_q;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs: one-hot grant and the beat that will be registered at the edge
  always_comb begin
    grant         = rst_n && (state_q != THROTTLE) && found && can_grant;
    req_ready     = '0;
    period_src    = (state_q == IDLE) ? sample_period : period_hold_q;
    ptr_d         = ptr_q;
    period_hold_d = period_hold_q;
    tvalid_d      = tvalid_q && !m_axis_tready;
    tlast_d       = tlast_q;
    tdata_d       = tdata_q;
    if (state_q == SWEEP && !found) ptr_d = '0;
    if (grant) begin
      req_ready[sel] = 1'b1;
      if (state_q == IDLE) period_hold_d = sample_period;
      tvalid_d       = 1'b1;
      tlast_d        = last;
      tdata_d.pad    = 2'b00;
      tdata_d.period = period_src;
      tdata_d.addr   = req_addr[sel];
      ptr_d          = last ? '0 : sel + 1'b1;
    end
  end

  // Datapath registers; reset drops any beat held for the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q         <= '0;
      period_hold_q <= PERIOD_W'(DEFAULT_PERIOD);
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tdata_q       <= '0;
    end else begin
      ptr_q         <= ptr_d;
      period_hold_q <= period_hold_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      tdata_q       <= tdata_d;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign sweep_active  = (state_q != IDLE);

`ifdef DRAM_ARB_STATS_EN
  logic [31:0] stat_grants_q, stat_grants_d, stat_thr_q, stat_thr_d;

  // Saturating event counters
  always_comb begin
    stat_grants_d = sat_inc(stat_grants_q, grant);
    stat_thr_d    = sat_inc(stat_thr_q, state_q == THROTTLE);
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grants_q <= '0;
      stat_thr_q    <= '0;
    end else begin
      stat_grants_q <= stat_grants_d;
      stat_thr_q    <= stat_thr_d;
    end
  end

  assign stat_grants          = stat_grants_q;
  assign stat_throttle_cycles = stat_thr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dram_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_read_arbiter
// Purpose  : Randomised and scenario stimulus for dram_read_arbiter, compared
//            against a sweep-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_read_arbiter;

  localparam int N  = 8;
  localparam int AW = 24;
  localparam int PW = 14;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0]         req_valid, req_ready;
  logic [PW-1:0]        sample_period;
  logic                 m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [39:0]          m_axis_tdata;
  logic                 fifo_prog_full, sweep_active;
`ifdef DRAM_ARB_STATS_EN
  logic [31:0]          stat_grants, stat_throttle_cycles;
`endif

  dram_read_arbiter #(.INSTRUMENT_COUNT(N), .ADDR_W(AW), .PERIOD_W(PW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_addr       (req_addr),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .sample_period  (sample_period),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tlast   (m_axis_tlast),
    .fifo_prog_full (fifo_prog_full),
`ifdef DRAM_ARB_STATS_EN
    .stat_grants          (stat_grants),
    .stat_throttle_cycles (stat_throttle_cycles),
`endif
    .sweep_active   (sweep_active)
  );

  always #5 clk = ~clk;

  // A pending request must hold with a stable address until it is granted
  for (genvar gi = 0; gi < N; gi++) begin : g_req_rule
    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (req_valid[gi] && !req_ready[gi]) |=> (req_valid[gi] && $stable(req_addr[gi])));
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: sweep-level view of the scheduler
  bit           m_in_sweep, m_throttled;
  int           m_next;
  logic [PW-1:0] m_period;
  bit           o_valid, o_last;
  logic [39:0]  o_data;
  int           m_grants, m_thr_cycles;
  logic [N-1:0] grant_seen;
  int           obs_gnt[$];
  int           acc_per[$];

  // Stimulus knobs (percent)
  int p_new = 0, p_ready = 100, p_pf = 0, p_per = 0;

  task automatic model_reset();
    m_in_sweep = 0; m_throttled = 0; m_next = 0;
    o_valid = 0; o_last = 0; o_data = '0;
    m_grants = 0; m_thr_cycles = 0; grant_seen = '0;
  endtask

  // Compare the current cycle against the model, then advance the model
  task automatic monitor();
    int pick, base;
    bit gnt, lst, slot_free;
    logic [N-1:0] exp_rdy;
    slot_free = !o_valid || m_axis_tready;
    base = m_in_sweep ? m_next : 0;
    pick = -1;
    for (int i = N - 1; i >= base; i--) if (req_valid[i]) pick = i;
    gnt = 0;
    if (m_throttled) m_thr_cycles++;
    else if (pick >= 0 && !fifo_prog_full && slot_free) gnt = 1;
    exp_rdy = '0;
    if (gnt) exp_rdy[pick] = 1'b1;

    check_eq("tvalid", m_axis_tvalid, o_valid);
    if (o_valid) begin
      check_eq("tdata", m_axis_tdata, o_data);
      check_eq("tlast", m_axis_tlast, o_last);
    end
    check_eq("sweep_active", sweep_active, m_in_sweep || m_throttled);
    check_eq("req_ready", req_ready, exp_rdy);

    for (int i = 0; i < N; i++) if (req_ready[i]) begin obs_gnt.push_back(i); break; end
    if (m_axis_tvalid && m_axis_tready) acc_per.push_back(int'(m_axis_tdata[37:24]));

    if (m_throttled) begin
      if (!fifo_prog_full) m_throttled = 0;
    end else if (pick >= 0 && fifo_prog_full) begin
      m_throttled = 1;
    end
    if (gnt) begin
      lst = 1;
      for (int j = pick + 1; j < N; j++) if (req_valid[j]) lst = 0;
      if (!m_in_sweep) m_period = sample_period;
      o_valid = 1; o_last = lst;
      o_data = {2'b00, m_period, req_addr[pick]};
      m_in_sweep = !lst; m_next = pick + 1;
      m_grants++;
    end else if (m_axis_tready) begin
      o_valid = 0;
    end
    grant_seen = req_ready;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (grant_seen[i]) req_valid[i] = 1'b0;
      if (!req_valid[i] && ($urandom_range(99) < p_new)) begin
        req_valid[i] = 1'b1;
        req_addr[i]  = AW'($urandom);
      end
    end
    m_axis_tready  = ($urandom_range(99) < p_ready);
    fifo_prog_full = ($urandom_range(99) < p_pf);
    if ($urandom_range(99) < p_per) sample_period = PW'($urandom);
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_until_idle(input string tag, input int max_cycles);
    int n = 0;
    while ((|req_valid || o_valid || m_throttled) && n < max_cycles) begin
      cycle();
      n++;
    end
    if (n >= max_cycles) check_eq({tag, "_timeout"}, 1, 0);
  endtask

  task automatic load_reqs(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) if (mask[i]) begin
      req_valid[i] = 1'b1;
      req_addr[i]  = AW'($urandom);
    end
  endtask

  task automatic check_order(input string tag, input int exp_q[$]);
    check_eq({tag, "_count"}, obs_gnt.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < obs_gnt.size(); k++)
      check_eq(tag, obs_gnt[k], exp_q[k]);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_addr = '0; m_axis_tready = 1'b1;
    fifo_prog_full = 1'b0; sample_period = 14'd2272;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_tvalid", m_axis_tvalid, 0);
    check_eq("rst_tdata", m_axis_tdata, 0);
    check_eq("rst_tlast", m_axis_tlast, 0);
    check_eq("rst_sweep_active", sweep_active, 0);
    check_eq("rst_req_ready", req_ready, 0);
    rst_n = 1'b1;

    // Sweep order and tlast
    obs_gnt.delete();
    load_reqs(8'b0010_0101);
    run_until_idle("sweep", 20);
    check_order("sweep_order", '{0, 2, 5});

    // Backpressure after the first beat
    obs_gnt.delete();
    load_reqs(8'hFF);
    cycle();
    p_ready = 0; m_axis_tready = 1'b0;
    repeat (4) cycle();
    p_ready = 100; m_axis_tready = 1'b1;
    run_until_idle("bp", 40);
    check_order("bp_order", '{0, 1, 2, 3, 4, 5, 6, 7});

    // Throttle mid-sweep
    obs_gnt.delete();
    load_reqs(8'hFF);
    repeat (3) cycle();
    p_pf = 100; fifo_prog_full = 1'b1;
    repeat (3) cycle();
    p_pf = 0; fifo_prog_full = 1'b0;
    run_until_idle("thr", 40);
    check_order("thr_order", '{0, 1, 2, 3, 4, 5, 6, 7});

    // Period latched at the start of each sweep
    acc_per.delete();
    sample_period = 14'd2272;
    load_reqs(8'hFF);
    repeat (2) cycle();
    sample_period = 14'd1136;
    run_until_idle("per1", 40);
    load_reqs(8'hFF);
    run_until_idle("per2", 40);
    check_eq("per_count", acc_per.size(), 16);
    for (int k = 0; k < acc_per.size() && k < 16; k++)
      check_eq("per_value", acc_per[k], (k < 8) ? 2272 : 1136);

    // Late requester waits for the next sweep
    obs_gnt.delete();
    load_reqs(8'b0100_1000);
    cycle();
    load_reqs(8'b0000_0010);
    run_until_idle("late", 30);
    check_order("late_order", '{3, 6, 1});

    // Randomised traffic
    p_new = 30; p_ready = 70; p_pf = 15; p_per = 5;
    repeat (3000) cycle();
    p_new = 0; p_ready = 100; p_pf = 0; p_per = 0;
    run_until_idle("rand", 200);
`ifdef DRAM_ARB_STATS_EN
    check_eq("stat_grants", stat_grants, m_grants);
    check_eq("stat_throttle", stat_throttle_cycles, m_thr_cycles);
`endif

    // Reset while a beat is stalled in the output register
    load_reqs(8'hFF);
    p_ready = 0; m_axis_tready = 1'b0;
    repeat (2) cycle();
    check_eq("pre_rst_tvalid", m_axis_tvalid, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_tvalid", m_axis_tvalid, 0);
    check_eq("mid_rst_tdata", m_axis_tdata, 0);
    check_eq("mid_rst_tlast", m_axis_tlast, 0);
    check_eq("mid_rst_sweep", sweep_active, 0);
    check_eq("mid_rst_ready", req_ready, 0);
    model_reset();
    req_valid = '0;
    load_reqs(8'hFF);
    @(posedge clk);
    #1;
    rst_n = 1'b1; p_ready = 100; m_axis_tready = 1'b1;
    obs_gnt.delete();
    run_until_idle("post_rst", 40);
    check_order("post_rst_order", '{0, 1, 2, 3, 4, 5, 6, 7});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
